// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute bundle for the operand stage, with the
// downstream forwarding inputs and ALU-facing outputs.
interface ex_operand_stage_if;
    logic        valid_in;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [15:0] imm;
    logic [2:0]  aluop_in;
    logic        alusrc_in;
    logic        regwrite_in;
    logic        stall;
    logic        flush;
    logic        exmem_regwrite;
    logic        memwb_regwrite;
    logic [2:0]  exmem_rd;
    logic [2:0]  memwb_rd;
    logic [15:0] exmem_result;
    logic [15:0] memwb_result;
    logic [15:0] alu_i1;
    logic [15:0] alu_i2;
    logic [2:0]  alu_op;
    logic [15:0] store_data;
    logic [2:0]  rd_out;
    logic        regwrite_out;
    logic        valid_out;

    modport master (
        output valid_in, rs_data, rt_data, rs_addr, rt_addr, rd_addr,
        output imm, aluop_in, alusrc_in, regwrite_in, stall, flush,
        output exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
        output exmem_result, memwb_result,
        input  alu_i1, alu_i2, alu_op, store_data,
        input  rd_out, regwrite_out, valid_out
    );

    modport slave (
        input  valid_in, rs_data, rt_data, rs_addr, rt_addr, rd_addr,
        input  imm, aluop_in, alusrc_in, regwrite_in, stall, flush,
        input  exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
        input  exmem_result, memwb_result,
        output alu_i1, alu_i2, alu_op, store_data,
        output rd_out, regwrite_out, valid_out
    );
endinterface

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register with EX/MEM and MEM/WB
// forwarding muxes feeding the ALU and store path.
module ex_operand_stage (
    input logic               clk,
    input logic               reset,
    ex_operand_stage_if.slave bus
);

    logic        valid_q;
    logic [15:0] rs_data_q;
    logic [15:0] rt_data_q;
    logic [2:0]  rs_addr_q;
    logic [2:0]  rt_addr_q;
    logic [2:0]  rd_q;
    logic [15:0] imm_q;
    logic [2:0]  aluop_q;
    logic        alusrc_q;
    logic        regwrite_q;

    logic [15:0] fwd_a;
    logic [15:0] fwd_b;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            valid_q    <= 1'b0;
            rs_data_q  <= 16'h0000;
            rt_data_q  <= 16'h0000;
            rs_addr_q  <= 3'd0;
            rt_addr_q  <= 3'd0;
            rd_q       <= 3'd0;
            imm_q      <= 16'h0000;
            aluop_q    <= 3'b000;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q    <= bus.valid_in;
            rs_data_q  <= bus.rs_data;
            rt_data_q  <= bus.rt_data;
            rs_addr_q  <= bus.rs_addr;
            rt_addr_q  <= bus.rt_addr;
            rd_q       <= bus.rd_addr;
            imm_q      <= bus.imm;
            aluop_q    <= bus.aluop_in;
            alusrc_q   <= bus.alusrc_in;
            regwrite_q <= bus.regwrite_in & bus.valid_in;
        end
    end

    // r0 is hard zero, so it never matches a forward and never
    // exposes whatever the register file happened to return.
    function automatic logic [15:0] forward(
        input logic [2:0]  addr,
        input logic [15:0] data,
        input logic        ex_we,
        input logic [2:0]  ex_rd,
        input logic [15:0] ex_res,
        input logic        wb_we,
        input logic [2:0]  wb_rd,
        input logic [15:0] wb_res
    );
        logic [15:0] r;
        r = data;
        if (addr == 3'd0)
            r = 16'h0000;
        else if (ex_we && ex_rd == addr)
            r = ex_res;
        else if (wb_we && wb_rd == addr)
            r = wb_res;
        return r;
    endfunction

    always_comb begin
        fwd_a = forward(rs_addr_q, rs_data_q,
                        bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result,
                        bus.memwb_regwrite, bus.memwb_rd,
                        bus.memwb_result);
        fwd_b = forward(rt_addr_q, rt_data_q,
                        bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result,
                        bus.memwb_regwrite, bus.memwb_rd,
                        bus.memwb_result);
    end

    assign bus.alu_i1       = fwd_a;
    assign bus.alu_i2       = alusrc_q ? imm_q : fwd_b;
    assign bus.store_data   = fwd_b;
    assign bus.alu_op       = aluop_q;
    assign bus.rd_out       = rd_q;
    assign bus.valid_out    = valid_q;
    assign bus.regwrite_out = regwrite_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and randomized checks of the execute operand stage
// against an instruction-record reference model.
module tb_ex_operand_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently held by the stage.
    typedef struct {
        logic        valid;
        logic [15:0] rsd;
        logic [15:0] rtd;
        logic [2:0]  rsa;
        logic [2:0]  rta;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [2:0]  op;
        logic        src;
        logic        rw;
    } instr_t;

    instr_t m;

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 1'b0; b.rsd = '0; b.rtd = '0;
        b.rsa = '0; b.rta = '0; b.rd = '0;
        b.imm = '0; b.op = '0; b.src = 1'b0; b.rw = 1'b0;
        return b;
    endfunction

    function automatic logic [15:0] src_val(
        input logic [2:0] a, input logic [15:0] d);
        if (a == 0) return 16'h0000;
        if (bus.exmem_regwrite && bus.exmem_rd == a)
            return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == a)
            return bus.memwb_result;
        return d;
    endfunction

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] b;
        b = src_val(m.rta, m.rtd);
        chk({tag, ".i1"}, bus.alu_i1, src_val(m.rsa, m.rsd));
        chk({tag, ".i2"}, bus.alu_i2, m.src ? m.imm : b);
        chk({tag, ".sd"}, bus.store_data, b);
        chk({tag, ".op"}, {13'd0, bus.alu_op}, {13'd0, m.op});
        chk({tag, ".rd"}, {13'd0, bus.rd_out}, {13'd0, m.rd});
        chk({tag, ".v"}, {15'd0, bus.valid_out}, {15'd0, m.valid});
        chk({tag, ".rw"}, {15'd0, bus.regwrite_out},
            {15'd0, m.rw && m.valid});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || bus.flush) begin
            m = bubble();
        end else if (!bus.stall) begin
            m.valid = bus.valid_in;
            m.rsd = bus.rs_data;  m.rtd = bus.rt_data;
            m.rsa = bus.rs_addr;  m.rta = bus.rt_addr;
            m.rd = bus.rd_addr;   m.imm = bus.imm;
            m.op = bus.aluop_in;  m.src = bus.alusrc_in;
            m.rw = bus.regwrite_in && bus.valid_in;
        end
        #1;
    endtask

    task automatic no_fwd();
        bus.exmem_regwrite = 0; bus.memwb_regwrite = 0;
        bus.exmem_rd = 0; bus.memwb_rd = 0;
        bus.exmem_result = 0; bus.memwb_result = 0;
    endtask

    task automatic set_instr(input logic [2:0] rsa,
                             input logic [15:0] rsd,
                             input logic [2:0] rta,
                             input logic [15:0] rtd,
                             input logic [2:0] rd,
                             input logic [2:0] op,
                             input logic src,
                             input logic [15:0] imm);
        bus.valid_in = 1; bus.regwrite_in = 1;
        bus.rs_addr = rsa; bus.rs_data = rsd;
        bus.rt_addr = rta; bus.rt_data = rtd;
        bus.rd_addr = rd; bus.aluop_in = op;
        bus.alusrc_in = src; bus.imm = imm;
    endtask

    task automatic rand_down();
        bus.exmem_regwrite = 1'($urandom);
        bus.memwb_regwrite = 1'($urandom);
        bus.exmem_rd = 3'($urandom);
        bus.memwb_rd = 3'($urandom);
        bus.exmem_result = 16'($urandom);
        bus.memwb_result = 16'($urandom);
    endtask

    task automatic rand_up();
        bus.valid_in = 1'($urandom);
        bus.regwrite_in = 1'($urandom);
        bus.rs_addr = 3'($urandom); bus.rt_addr = 3'($urandom);
        bus.rd_addr = 3'($urandom);
        bus.rs_data = 16'($urandom); bus.rt_data = 16'($urandom);
        bus.imm = 16'($urandom); bus.aluop_in = 3'($urandom);
        bus.alusrc_in = 1'($urandom);
    endtask

    initial begin
        m = bubble();
        reset = 1; bus.stall = 0; bus.flush = 0;
        set_instr(3'd5, 16'hDEAD, 3'd6, 16'hBEEF, 3'd7, 3'd5, 1, 16'h1);
        no_fwd();
        tick(); tick();
        chk("rst.v", {15'd0, bus.valid_out}, 16'h0);
        chk("rst.rw", {15'd0, bus.regwrite_out}, 16'h0);
        chk("rst.rd", {13'd0, bus.rd_out}, 16'h0);
        chk("rst.op", {13'd0, bus.alu_op}, 16'h0);
        chk("rst.i1", bus.alu_i1, 16'h0);
        chk("rst.i2", bus.alu_i2, 16'h0);
        chk("rst.sd", bus.store_data, 16'h0);
        reset = 0;

        // basic load
        set_instr(3'd1, 16'h0005, 3'd2, 16'h0003, 3'd3, 3'd1, 0, 16'h0);
        tick();
        chk("ld.i1", bus.alu_i1, 16'h0005);
        chk("ld.i2", bus.alu_i2, 16'h0003);
        chk("ld.op", {13'd0, bus.alu_op}, 16'h1);
        chk("ld.rd", {13'd0, bus.rd_out}, 16'h3);
        chk("ld.rw", {15'd0, bus.regwrite_out}, 16'h1);
        check_all("ld");

        // forwarding priority
        set_instr(3'd2, 16'h1111, 3'd3, 16'h2222, 3'd4, 3'd2, 0, 16'h0);
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 2;
        bus.exmem_result = 16'h00AA;
        bus.memwb_regwrite = 1; bus.memwb_rd = 2;
        bus.memwb_result = 16'h00BB;
        #1;
        chk("fwd.ex", bus.alu_i1, 16'h00AA);
        bus.exmem_regwrite = 0;
        #1;
        chk("fwd.wb", bus.alu_i1, 16'h00BB);
        check_all("fwd");
        no_fwd();

        // r0 never forwards
        set_instr(3'd1, 16'h0001, 3'd0, 16'h7777, 3'd1, 3'd3, 0, 16'h0);
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 0;
        bus.exmem_result = 16'hFFFF;
        #1;
        chk("r0.sd", bus.store_data, 16'h0000);
        chk("r0.i2", bus.alu_i2, 16'h0000);
        no_fwd();

        // immediate vs store data
        set_instr(3'd1, 16'h0001, 3'd4, 16'h0000, 3'd5, 3'd4, 1, 16'hFFF8);
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 4;
        bus.exmem_result = 16'h1234;
        #1;
        chk("imm.i2", bus.alu_i2, 16'hFFF8);
        chk("imm.sd", bus.store_data, 16'h1234);
        no_fwd();

        // stall holds, flush beats stall
        set_instr(3'd3, 16'h0C0C, 3'd5, 16'h0505, 3'd6, 3'd6, 0, 16'h0);
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_up();
            tick();
            chk("stl.i1", bus.alu_i1, 16'h0C0C);
            chk("stl.i2", bus.alu_i2, 16'h0505);
            chk("stl.op", {13'd0, bus.alu_op}, 16'h6);
            chk("stl.rd", {13'd0, bus.rd_out}, 16'h6);
            chk("stl.v", {15'd0, bus.valid_out}, 16'h1);
        end
        bus.flush = 1;
        tick();
        chk("fls.v", {15'd0, bus.valid_out}, 16'h0);
        chk("fls.rw", {15'd0, bus.regwrite_out}, 16'h0);
        bus.flush = 0; bus.stall = 0;

        // reset during stall discards held instruction
        set_instr(3'd1, 16'h0042, 3'd2, 16'h0043, 3'd7, 3'd7, 0, 16'h0);
        tick();
        bus.stall = 1; reset = 1;
        tick();
        chk("rstl.v", {15'd0, bus.valid_out}, 16'h0);
        chk("rstl.op", {13'd0, bus.alu_op}, 16'h0);
        chk("rstl.rd", {13'd0, bus.rd_out}, 16'h0);
        reset = 0; bus.stall = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            rand_up();
            rand_down();
            tick();
            check_all("rnd");
            rand_down();
            #1;
            check_all("rndc");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- REQ-003: valid_in  input  1  decode stage presents a valid instruction.
- REQ-004: rs_data, rt_data  input  16 each  register-file read data.
- REQ-005: rs_addr, rt_addr, rd_addr  input  3 each  source and destination register numbers; r0 reads as zero and is never written.
- REQ-006: imm  input  16  immediate, already sign-extended by decode.
- REQ-007: aluop_in  input  3  ALU opcode, passed through unchanged.
- REQ-008: alusrc_in, regwrite_in  input  1 each  select imm as operand B; instruction writes rd.
- REQ-009: stall, flush  input  1 each  hold stage contents; replace stage contents with a bubble.
- REQ-010: exmem_regwrite, memwb_regwrite  input  1 each  downstream write enables.
- REQ-011: exmem_rd, memwb_rd  input  3 each  downstream destination registers.
- REQ-012: exmem_result, memwb_result  input  16 each  downstream result values.
- REQ-013: alu_i1, alu_i2  output  16 each  ALU operands A and B.
- REQ-014: alu_op  output  3  ALU opcode.
- REQ-015: store_data  output  16  forwarded rt value for stores.
- REQ-016: rd_out, regwrite_out, valid_out  output  3/1/1  registered destination, write enable, valid.

Function
- REQ-017: Stage register SHALL hold valid, rs/rt data, rs/rt/rd addr, imm, aluop, alusrc, regwrite; latency is exactly 1 cycle from input to output.
- REQ-018: Edge priority SHALL be reset > flush > stall > load.
- REQ-019: On flush (no reset), stage SHALL load a bubble: valid=0, regwrite=0, aluop=000, all data and address fields 0.
- REQ-020: On stall (no reset, no flush), stage SHALL keep every field unchanged.
- REQ-021: Otherwise stage SHALL load all inputs; if valid_in=0, regwrite SHALL load as 0.
- REQ-022: regwrite_out SHALL equal the stored regwrite AND stored valid.
- REQ-023: Forwarded A SHALL be: exmem_result if exmem_regwrite=1, exmem_rd=stored rs_addr and exmem_rd!=0; else memwb_result under the same rule with memwb signals; else stored rs_data.
- REQ-024: Forwarded B SHALL follow the REQ-023 rule applied to stored rt_addr/rt_data.
- REQ-025: EX/MEM SHALL take priority over MEM/WB when both match.
- REQ-026: Forwarding SHALL be combinational on stored addresses and live downstream inputs, evaluated every cycle including stalled cycles.
- REQ-027: A source address of 0 SHALL never forward and SHALL yield 16'h0000 regardless of stored data.
- REQ-028: alu_i1 SHALL be forwarded A; alu_i2 SHALL be imm if stored alusrc=1, else forwarded B; store_data SHALL always be forwarded B.
- REQ-029: No arithmetic is performed; all 16-bit values SHALL pass unmodified.

Reset
- REQ-030: While reset is high at a clock edge, stage SHALL load the bubble of REQ-019, overriding flush and stall.
- REQ-031: After reset: valid_out=0, regwrite_out=0, rd_out=0, alu_op=000, alu_i1=alu_i2=store_data=16'h0000 (absent matching forwards).
- REQ-032: Reset asserted mid-stall SHALL discard the held instruction.

Verification
- REQ-033: Load rs=1 (16'h0005), rt=2 (16'h0003), rd=3, aluop=001, alusrc=0, no forwards -> next cycle alu_i1=0005, alu_i2=0003, alu_op=001, rd_out=3, regwrite_out=1.
- REQ-034: Stored rs=2, exmem_regwrite=1, exmem_rd=2, exmem_result=00AA; memwb_regwrite=1, memwb_rd=2, memwb_result=00BB -> alu_i1=00AA; drop exmem_regwrite -> alu_i1=00BB.
- REQ-035: Stored rt=0, exmem_rd=0, exmem_regwrite=1, exmem_result=FFFF -> store_data=0000, alu_i2=0000 (alusrc=0).
- REQ-036: alusrc=1, imm=FFF8, rt forward active with 1234 -> alu_i2=FFF8, store_data=1234.
- REQ-037: stall high 3 cycles while inputs change -> outputs constant; flush and stall together -> valid_out=0, regwrite_out=0.
- REQ-038: reset with stall high and valid instruction stored -> next cycle valid_out=0, alu_op=000, rd_out=0.
